// File: rtl/nv_ram_rwsp_fifo_ctrl_256x257_pkg.sv
// rtl/nv_ram_rwsp_fifo_ctrl_256x257_pkg.sv - shared RAM geometry and status defaults
//
// Purpose : geometry of the 256x257 two-port RAM sequenced by the FIFO controller,
//           plus the default almost-full threshold.
// Ports   : none (package).
package nv_ram_rwsp_fifo_ctrl_256x257_pkg;

    localparam int RAM_DEPTH            = 256;
    localparam int RAM_AW               = 8;
    localparam int RAM_DW               = 257;
    // One more bit than the address so a full RAM (256) plus the output register (257) fits.
    localparam int RAM_CW               = 9;
    localparam int AFULL_THRESH_DEFAULT = 240;

endpackage

// File: rtl/nv_fifo_rdpipe2.sv
// rtl/nv_fifo_rdpipe2.sv - two-stage RAM read pipeline controller
//
// Purpose : tracks the registered read address (stage 1) and the RAM output register
//           (stage 2), deciding when a new read may be issued and when stage 1 may
//           move into the output register.
// Ports   : clk, rstn       - clock, synchronous active-low reset
//           avail_nz        - at least one written word has no read issued yet
//           pop             - consumer takes the word held in stage 2
//           issue           - load a new read address this cycle
//           s1_adv          - capture stage 1 into the output register this cycle
//           s1_vld, s2_vld  - stage occupancy
module nv_fifo_rdpipe2 (
    input  logic clk,
    input  logic rstn,
    input  logic avail_nz,
    input  logic pop,
    output logic issue,
    output logic s1_adv,
    output logic s1_vld,
    output logic s2_vld
);

    logic s1_vld_q, s1_vld_d;
    logic s2_vld_q, s2_vld_d;

    always_comb begin
        // Stage 1 moves on when the output register is empty or is being emptied now.
        s1_adv   = s1_vld_q & (~s2_vld_q | pop);
        // A new address may only be loaded when stage 1 is free or vacating this cycle,
        // so a held address is never overwritten.
        issue    = avail_nz & (~s1_vld_q | s1_adv);
        s1_vld_d = issue | (s1_vld_q & ~s1_adv);
        s2_vld_d = s1_adv | (s2_vld_q & ~pop);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
        end
    end

    assign s1_vld = s1_vld_q;
    assign s2_vld = s2_vld_q;

endmodule

// File: rtl/nv_ram_rwsp_fifo_ctrl_256x257.sv
// rtl/nv_ram_rwsp_fifo_ctrl_256x257.sv - valid/ready FIFO controller for a 256x257 two-port RAM
//
// Purpose : sequences a two-port RAM with registered read address and output register so
//           that push and pop each sustain one word per cycle and RAM read latency is hidden.
// Ports   : nvdla_core_clk, nvdla_core_rstn - clock, synchronous active-low reset
//           wr_pvld/wr_prdy/wr_pd           - push stream
//           rd_pvld/rd_prdy/rd_pd           - pop stream (rd_pd is the RAM output register)
//           ram_we/ram_wa/ram_di            - RAM write port
//           ram_re/ram_ra                   - RAM read-address register load
//           ram_ore/ram_dout                - RAM output-register enable and contents
//           fifo_count, fifo_afull          - occupancy status
module nv_ram_rwsp_fifo_ctrl_256x257
    import nv_ram_rwsp_fifo_ctrl_256x257_pkg::*;
#(
    parameter int AFULL_THRESH = AFULL_THRESH_DEFAULT
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              wr_pvld,
    output logic              wr_prdy,
    input  logic [RAM_DW-1:0] wr_pd,
    output logic              rd_pvld,
    input  logic              rd_prdy,
    output logic [RAM_DW-1:0] rd_pd,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_wa,
    output logic [RAM_DW-1:0] ram_di,
    output logic              ram_re,
    output logic [RAM_AW-1:0] ram_ra,
    output logic              ram_ore,
    input  logic [RAM_DW-1:0] ram_dout,
    output logic [RAM_CW-1:0] fifo_count,
    output logic              fifo_afull
);

    localparam logic [RAM_CW-1:0] OCC_FULL  = RAM_CW'(RAM_DEPTH);
    localparam logic [RAM_CW-1:0] AFULL_LVL = RAM_CW'(AFULL_THRESH);

    logic [RAM_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [RAM_AW-1:0] rd_ptr_q, rd_ptr_d;
    // Words in RAM not yet captured by the output register; bounds the write side.
    logic [RAM_CW-1:0] occ_q, occ_d;
    // Words written in earlier cycles with no read issued; gates read issue.
    logic [RAM_CW-1:0] avail_q, avail_d;

    logic push;
    logic pop;
    logic issue;
    logic s1_adv;
    logic s1_vld;
    logic s2_vld;

    nv_fifo_rdpipe2 u_rdpipe (
        .clk      (nvdla_core_clk),
        .rstn     (nvdla_core_rstn),
        .avail_nz (avail_q != '0),
        .pop      (pop),
        .issue    (issue),
        .s1_adv   (s1_adv),
        .s1_vld   (s1_vld),
        .s2_vld   (s2_vld)
    );

    always_comb begin
        // Ready depends only on RAM occupancy: a slot freed by s1_adv this cycle is not
        // reusable until the next cycle, so the write never races the captured read.
        wr_prdy  = (occ_q != OCC_FULL);
        push     = wr_pvld & wr_prdy;
        pop      = s2_vld & rd_prdy;

        wr_ptr_d = wr_ptr_q + RAM_AW'(push);
        rd_ptr_d = rd_ptr_q + RAM_AW'(issue);
        avail_d  = avail_q + RAM_CW'(push) - RAM_CW'(issue);
        occ_d    = occ_q + RAM_CW'(push) - RAM_CW'(s1_adv);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            avail_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            avail_q  <= avail_d;
        end
    end

    assign ram_we     = push;
    assign ram_wa     = wr_ptr_q;
    assign ram_di     = wr_pd;
    assign ram_re     = issue;
    assign ram_ra     = rd_ptr_q;
    assign ram_ore    = s1_adv;
    assign rd_pvld    = s2_vld;
    assign rd_pd      = ram_dout;
    assign fifo_count = occ_q + RAM_CW'(s2_vld);
    assign fifo_afull = (occ_q >= AFULL_LVL);

    // A latched read address that cannot advance must never be reloaded.
    a_no_reissue_while_held: assert property (
        @(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        !(issue && s1_vld && !s1_adv)
    );

endmodule
